// File: rtl/wallace_tree_arbiter_if.sv
// wallace_tree_arbiter_if: operand request and product response handshakes for two requesters
interface wallace_tree_arbiter_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req_a0;
  logic [3:0] req_b0;
  logic [3:0] req_a1;
  logic [3:0] req_b1;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [7:0] rsp_p0;
  logic [7:0] rsp_p1;
  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_p0, rsp_p1
  );
  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_p0, rsp_p1
  );
endinterface

// File: rtl/wallace_tree_arbiter.sv
// wallace_tree_arbiter: round-robin sharing of one 4x4 signed Wallace-tree multiplier between two requesters
module wallace_tree (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  logic [3:0][3:0] pp;
  logic s2, c2, s3, c3, s4, c4, s5, c5, t3, d3, t4, d4, u5, e5, h6, g7;
  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (z & (x ^ y)), x ^ y ^ z};
  endfunction
  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction
  // Baugh-Wooley: terms touching exactly one sign bit are inverted, 1s at bits 4 and 7 correct the sum
  for (genvar i = 0; i < 4; i++) begin : g_row
    for (genvar j = 0; j < 4; j++) begin : g_col
      assign pp[i][j] = (a_i[j] & b_i[i]) ^ ((i == 3) != (j == 3));
    end
  end
  always_comb begin
    {c2, s2} = fa(pp[0][2], pp[1][1], pp[2][0]);
    {c3, s3} = fa(pp[0][3], pp[1][2], pp[2][1]);
    {c4, s4} = fa(pp[1][3], pp[2][2], pp[3][1]);
    {c5, s5} = ha(pp[2][3], pp[3][2]);
    {d3, t3} = fa(s3, pp[3][0], c2);
    {d4, t4} = fa(s4, 1'b1, c3);
    {e5, u5} = fa(s5, c4, d4);
    {g7, h6} = ha(pp[3][3], c5);
    p_o = {1'b1, h6, u5, t4, t3, s2, pp[0][1], pp[0][0]} + {g7, e5, 1'b0, d3, 2'b00, pp[1][0], 1'b0};
  end
endmodule

module wallace_tree_arbiter #(
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  wallace_tree_arbiter_if.slave bus,
  output logic                  busy_o,
  output logic [7:0]            done_cnt0_o,
  output logic [7:0]            done_cnt1_o
);
  logic            op_valid_q, op_valid_d, op_tag_q, op_tag_d, last_q, last_d;
  logic [3:0]      op_a_q, op_a_d, op_b_q, op_b_d;
  logic [1:0]      rsp_full_q, rsp_full_d;
  logic [1:0][7:0] rsp_p_q, rsp_p_d, done_cnt_q, done_cnt_d;
  logic [1:0]      elig, cand, grant, drain, cap;
  logic [7:0]      prod;
  wallace_tree u_mul (.a_i(op_a_q), .b_i(op_b_q), .p_o(prod));
  // a requester with a full buffer or an op in flight waits, so each has at most one outstanding
  always_comb begin
    elig = ~rsp_full_q & ~({op_tag_q, ~op_tag_q} & {2{op_valid_q}});
    cand = bus.req_valid & elig;
    grant = rst ? 2'b00 : &cand ? (last_q ? 2'b01 : 2'b10) : cand;
    drain = rsp_full_q & bus.rsp_ready;
    cap = {op_valid_q & op_tag_q, op_valid_q & ~op_tag_q};
    op_valid_d = |grant;
    op_tag_d = op_valid_d ? grant[1] : op_tag_q;
    last_d = op_valid_d ? grant[1] : last_q;
    op_a_d = op_valid_d ? (grant[1] ? bus.req_a1 : bus.req_a0) : op_a_q;
    op_b_d = op_valid_d ? (grant[1] ? bus.req_b1 : bus.req_b0) : op_b_q;
    rsp_full_d = (rsp_full_q & ~drain) | cap;
    for (int i = 0; i < 2; i++) begin
      rsp_p_d[i] = cap[i] ? prod : rsp_p_q[i];
      done_cnt_d[i] = done_cnt_q[i] + 8'(drain[i]);
    end
  end
  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_full_q;
  assign bus.rsp_p0 = rsp_p_q[0];
  assign bus.rsp_p1 = rsp_p_q[1];
  assign busy_o = op_valid_q;
  assign done_cnt0_o = done_cnt_q[0];
  assign done_cnt1_o = done_cnt_q[1];
  always_ff @(posedge clk)
    if (rst) begin
      op_valid_q <= 1'b0;
      op_tag_q <= 1'b0;
      last_q <= ~PRIO_RESET;
      op_a_q <= '0;
      op_b_q <= '0;
      rsp_full_q <= '0;
      rsp_p_q <= '0;
      done_cnt_q <= '0;
    end else begin
      op_valid_q <= op_valid_d;
      op_tag_q <= op_tag_d;
      last_q <= last_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      rsp_full_q <= rsp_full_d;
      rsp_p_q <= rsp_p_d;
      done_cnt_q <= done_cnt_d;
    end
endmodule

// File: tb/tb_wallace_tree_arbiter.sv
// tb_wallace_tree_arbiter: directed and random stimulus against a transaction-level arbiter model
module tb_wallace_tree_arbiter;
  localparam bit PRIO = 1'b0;
  logic clk = 1'b0;
  logic rst;
  logic busy_o;
  logic [7:0] done_cnt0_o, done_cnt1_o;
  int tests = 0;
  int fails = 0;
  wallace_tree_arbiter_if bus();
  wallace_tree_arbiter #(.PRIO_RESET(PRIO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy_o(busy_o),
    .done_cnt0_o(done_cnt0_o), .done_cnt1_o(done_cnt1_o)
  );
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: no event within 40 cycles at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int r);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.req_ready[r]) return;
      tick();
    end
    timeout("wait_ready");
  endtask

  task automatic wait_rsp(input int r);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.rsp_valid[r]) return;
      tick();
    end
    timeout("wait_rsp");
  endtask

  task automatic do_op(input int r, input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp, input string name);
    if (r == 0) begin
      bus.req_a0 = a;
      bus.req_b0 = b;
    end else begin
      bus.req_a1 = a;
      bus.req_b1 = b;
    end
    bus.req_valid[r] = 1'b1;
    wait_ready(r);
    tick();
    bus.req_valid[r] = 1'b0;
    wait_rsp(r);
    check(name, r == 0 ? int'(bus.rsp_p0) : int'(bus.rsp_p1), int'(exp));
    tick();
  endtask

  // transaction-level model: stage holds the already-computed product, buffers hold results
  bit mv = 1'b0;
  bit m_full[2];
  int m_prod[2];
  int m_cnt[2];
  bit m_sv;
  int m_st, m_sp, m_last, w;
  bit c[2];
  logic [3:0] ca[2], cb[2], p_a[2], p_b[2];
  logic [1:0] p_v, p_r;
  bit p_rst = 1'b1;

  initial forever begin
    @(negedge clk);
    ca[0] = bus.req_a0; cb[0] = bus.req_b0;
    ca[1] = bus.req_a1; cb[1] = bus.req_b1;
    for (int i = 0; i < 2; i++) c[i] = bus.req_valid[i] && !m_full[i] && !(m_sv && m_st == i);
    w = -1;
    if (!rst) begin
      if (c[0] && c[1]) w = 1 - m_last;
      else if (c[0]) w = 0;
      else if (c[1]) w = 1;
    end
    if (mv) begin
      check("req_ready", int'(bus.req_ready), w < 0 ? 0 : 1 << w);
      check("rsp_valid", int'(bus.rsp_valid), 2 * m_full[1] + m_full[0]);
      if (m_full[0]) check("rsp_p0", $signed(bus.rsp_p0), m_prod[0]);
      if (m_full[1]) check("rsp_p1", $signed(bus.rsp_p1), m_prod[1]);
      check("busy", int'(busy_o), int'(m_sv));
      check("done_cnt0", int'(done_cnt0_o), m_cnt[0]);
      check("done_cnt1", int'(done_cnt1_o), m_cnt[1]);
    end
    for (int i = 0; i < 2; i++)
      if (!p_rst && p_v[i] && !p_r[i] && bus.req_valid[i])
        check("hold_contract", int'({ca[i], cb[i]}), int'({p_a[i], p_b[i]}));
    p_v = bus.req_valid;
    p_r = bus.req_ready;
    p_a = ca;
    p_b = cb;
    p_rst = rst;
    if (rst) begin
      mv = 1'b1;
      m_sv = 1'b0;
      m_last = 1 - int'(PRIO);
      for (int i = 0; i < 2; i++) begin
        m_full[i] = 1'b0;
        m_prod[i] = 0;
        m_cnt[i] = 0;
      end
    end else if (mv) begin
      for (int i = 0; i < 2; i++)
        if (m_full[i] && bus.rsp_ready[i]) begin
          m_full[i] = 1'b0;
          m_cnt[i] = (m_cnt[i] + 1) % 256;
        end
      if (m_sv) begin
        m_full[m_st] = 1'b1;
        m_prod[m_st] = m_sp;
        m_sv = 1'b0;
      end
      if (w >= 0) begin
        int x, y;
        x = $signed(ca[w]);
        y = $signed(cb[w]);
        m_sv = 1'b1;
        m_st = w;
        m_sp = x * y;
        m_last = w;
      end
    end
  end

  initial begin
    logic [1:0] r;
    logic [7:0] base1;
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_a0 = '0; bus.req_b0 = '0; bus.req_a1 = '0; bus.req_b1 = '0;
    bus.rsp_ready = 2'b00;
    tick();
    tick();
    @(negedge clk);
    check("reset_req_ready", int'(bus.req_ready), 0);
    check("reset_rsp_valid", int'(bus.rsp_valid), 0);
    check("reset_busy", int'(busy_o), 0);
    check("reset_cnt0", int'(done_cnt0_o), 0);
    check("reset_cnt1", int'(done_cnt1_o), 0);
    check("reset_p0", int'(bus.rsp_p0), 0);
    check("reset_p1", int'(bus.rsp_p1), 0);
    tick();
    rst = 1'b0;
    bus.req_valid = 2'b01;
    bus.req_a0 = 4'd3;
    bus.req_b0 = 4'd5;
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    check("t1_ready", int'(bus.req_ready), 1);
    tick();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("t1_busy", int'(busy_o), 1);
    check("t1_rsp_early", int'(bus.rsp_valid), 0);
    tick();
    @(negedge clk);
    check("t1_rsp_valid", int'(bus.rsp_valid), 1);
    check("t1_p0", int'(bus.rsp_p0), 8'h0F);
    tick();
    @(negedge clk);
    check("t1_cnt0", int'(done_cnt0_o), 1);
    tick();
    do_op(1, 4'h8, 4'h8, 8'h40, "corner_m8_m8");
    do_op(1, 4'h8, 4'h7, 8'hC8, "corner_m8_7");
    do_op(1, 4'hF, 4'h1, 8'hFF, "corner_m1_1");
    do_op(1, 4'h0, 4'h8, 8'h00, "corner_0_m8");
    bus.req_a0 = 4'd2; bus.req_b0 = 4'd3;
    bus.req_a1 = 4'hE; bus.req_b1 = 4'd5;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("fair_grant", int'(bus.req_ready), k % 3 == 0 ? 1 : k % 3 == 1 ? 2 : 0);
      check("fair_busy", int'(busy_o), int'(k % 3 != 0));
      tick();
    end
    bus.req_valid = 2'b00;
    repeat (4) tick();
    @(negedge clk);
    check("fair_cnt0", int'(done_cnt0_o), 5);
    check("fair_cnt1", int'(done_cnt1_o), 8);
    tick();
    bus.rsp_ready = 2'b10;
    bus.req_a0 = 4'hD; bus.req_b0 = 4'h4;
    bus.req_valid = 2'b01;
    wait_ready(0);
    tick();
    bus.req_a0 = 4'h1; bus.req_b0 = 4'h1;
    bus.req_a1 = 4'h3; bus.req_b1 = 4'hE;
    bus.req_valid = 2'b11;
    wait_rsp(0);
    check("bp_p0_first", int'(bus.rsp_p0), 8'hF4);
    base1 = done_cnt1_o;
    for (int k = 0; k < 9; k++) begin
      tick();
      @(negedge clk);
      check("bp_ready0", int'(bus.req_ready[0]), 0);
      check("bp_p0_hold", int'(bus.rsp_p0), 8'hF4);
    end
    check("bp_req1_progress", int'(8'(done_cnt1_o - base1) >= 8'd2), 1);
    tick();
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    check("bp_drain_cycle_ready0", int'(bus.req_ready[0]), 0);
    tick();
    @(negedge clk);
    check("bp_reaccept", int'(bus.req_ready[0]), 1);
    tick();
    bus.req_valid = 2'b00;
    repeat (5) tick();
    bus.req_a0 = 4'd7; bus.req_b0 = 4'd7;
    bus.req_valid = 2'b01;
    wait_ready(0);
    tick();
    rst = 1'b1;
    bus.req_valid = 2'b00;
    tick();
    rst = 1'b0;
    bus.req_a0 = 4'd2; bus.req_b0 = 4'd2;
    bus.req_a1 = 4'd3; bus.req_b1 = 4'd3;
    bus.req_valid = 2'b11;
    @(negedge clk);
    check("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_cnt0", int'(done_cnt0_o), 0);
    check("rst_cnt1", int'(done_cnt1_o), 0);
    check("rst_tie", int'(bus.req_ready), 1);
    tick();
    bus.req_valid = 2'b10;
    wait_ready(1);
    tick();
    bus.req_valid = 2'b00;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 256; n++) begin
      bus.req_a0 = 4'($urandom);
      bus.req_b0 = 4'($urandom);
      bus.req_valid = 2'b01;
      wait_ready(0);
      if (n == 255) check("pre_wrap_cnt0", int'(done_cnt0_o), 255);
      tick();
    end
    bus.req_valid = 2'b00;
    repeat (4) tick();
    @(negedge clk);
    check("wrap_cnt0", int'(done_cnt0_o), 0);
    check("wrap_cnt1", int'(done_cnt1_o), 0);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      r = bus.req_ready;
      tick();
      rst = ($urandom_range(0, 249) == 0);
      for (int i = 0; i < 2; i++)
        if (!bus.req_valid[i] || r[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 3) != 0);
          if (i == 0) {bus.req_a0, bus.req_b0} = 8'($urandom);
          else {bus.req_a1, bus.req_b1} = 8'($urandom);
        end
      bus.rsp_ready = 2'($urandom_range(0, 3));
    end
    rst = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
